// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache miss controller: default widths,
// the ack timeout, the FSM state encoding and the saturating counter helper.
package cache_pkg;

    localparam int CACHE_ADDR_W  = 8;   // tag (6) + set (2)
    localparam int CACHE_DATA_W  = 16;
    localparam int CACHE_TIMEOUT = 15;  // legal 1..255
    localparam int CNT_W         = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_FILL    = 2'd2,
        S_WR_WAIT = 2'd3
    } state_t;

    // Timeout counter increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_wbuf.sv
// One-entry posted write buffer. A load captures address and data and marks
// the entry full; a clear empties it once the SRAM write has been retired.
// Only instantiated when CACHE_WBUF_EN is defined.
module cache_wbuf
    import cache_pkg::*;
#(
    parameter int ADDR_W = CACHE_ADDR_W,
    parameter int DATA_W = CACHE_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              full,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // Entry storage; load has priority (load and clear never coincide).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (load) begin
            full <= 1'b1;
            addr <= load_addr;
            data <= load_data;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cache_miss_ctrl.sv
// Cache miss controller: services read misses from the SRAM and refills the
// cache, writes every store through to the SRAM, and freezes the pipeline
// while an SRAM transaction is outstanding. A missing mem_ack aborts after
// TIMEOUT cycles with a bus_err pulse.
// Optional: define CACHE_WBUF_EN to add a one-entry posted write buffer.
module cache_miss_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W  = CACHE_ADDR_W,
    parameter int DATA_W  = CACHE_DATA_W,
    parameter int TIMEOUT = CACHE_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cache_hit,
    output logic              stall,
    output logic [DATA_W-1:0] rdata_out,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [DATA_W-1:0] fill_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              bus_err
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             timed_out;
    logic             read_miss;

    assign cnt_next  = sat_inc(cnt);
    assign timed_out = (cnt_next >= TMO);
    assign read_miss = cpu_re && !cache_hit;

`ifdef CACHE_WBUF_EN
    logic              wb_full;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_load;
    logic              wb_clear;
    logic              wb_hit;

    // Every SRAM write is a buffer drain, so retiring WR_WAIT empties the entry.
    assign wb_load  = (state == S_IDLE) && cpu_we && !wb_full;
    assign wb_clear = (state == S_WR_WAIT) && (mem_ack || timed_out);
    assign wb_hit   = wb_full && (wb_addr == cpu_addr);

    cache_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .load      (wb_load),
        .clear     (wb_clear),
        .load_addr (cpu_addr),
        .load_data (cpu_wdata),
        .full      (wb_full),
        .addr      (wb_addr),
        .data      (wb_data)
    );
`endif

    // Pipeline freeze: busy waiting on the SRAM, or a request in IDLE that
    // cannot complete this cycle (visible in the request cycle itself).
    always_comb begin
        stall = (state == S_RD_WAIT) || (state == S_WR_WAIT);
`ifdef CACHE_WBUF_EN
        if (state == S_IDLE)
            stall = cpu_we ? wb_full : read_miss;
`else
        if (state == S_IDLE)
            stall = cpu_we || read_miss;
`endif
    end

    // Controller FSM with registered SRAM, refill and error outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            rdata_out <= '0;
            fill_we   <= 1'b0;
            fill_addr <= '0;
            fill_data <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            fill_we <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
`ifdef CACHE_WBUF_EN
                    if (cpu_we) begin
                        if (wb_full) begin
                            state     <= S_WR_WAIT;
                            mem_wr    <= 1'b1;
                            mem_addr  <= wb_addr;
                            mem_wdata <= wb_data;
                        end
                    end else if (read_miss && wb_hit) begin
                        // Buffered store satisfies the miss without the SRAM.
                        state     <= S_FILL;
                        fill_we   <= 1'b1;
                        fill_addr <= cpu_addr;
                        fill_data <= wb_data;
                        rdata_out <= wb_data;
                    end else if (wb_full) begin
                        state     <= S_WR_WAIT;
                        mem_wr    <= 1'b1;
                        mem_addr  <= wb_addr;
                        mem_wdata <= wb_data;
                    end else if (read_miss) begin
                        state    <= S_RD_WAIT;
                        mem_rd   <= 1'b1;
                        mem_addr <= cpu_addr;
                    end
`else
                    if (cpu_we) begin
                        state     <= S_WR_WAIT;
                        mem_wr    <= 1'b1;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                    end else if (read_miss) begin
                        state    <= S_RD_WAIT;
                        mem_rd   <= 1'b1;
                        mem_addr <= cpu_addr;
                    end
`endif
                end
                S_RD_WAIT: begin
                    if (mem_ack) begin
                        state     <= S_FILL;
                        mem_rd    <= 1'b0;
                        rdata_out <= mem_rdata;
                        fill_data <= mem_rdata;
                        fill_addr <= mem_addr;
                        fill_we   <= 1'b1;
                    end else if (timed_out) begin
                        state     <= S_IDLE;
                        mem_rd    <= 1'b0;
                        bus_err   <= 1'b1;
                        rdata_out <= '1;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                S_FILL: begin
                    state <= S_IDLE;
                end
                S_WR_WAIT: begin
                    if (mem_ack) begin
                        state  <= S_IDLE;
                        mem_wr <= 1'b0;
                    end else if (timed_out) begin
                        state     <= S_IDLE;
                        mem_wr    <= 1'b0;
                        bus_err   <= 1'b1;
                        rdata_out <= '1;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl (default build). Each transaction is issued for
// one request cycle and observed over a fixed window; the expected stall,
// request, refill and error counts come from the latency/timeout rules.
module tb_cache_miss_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 15;
    localparam int WIN = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_re, cpu_we, cache_hit;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          stall, fill_we, mem_rd, mem_wr, mem_ack, bus_err;
    logic [DW-1:0] rdata_out, fill_data, mem_wdata, mem_rdata;
    logic [AW-1:0] fill_addr, mem_addr;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    exp_rdata;

    always #5 clk = ~clk;

    cache_miss_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cache_hit (cache_hit),
        .stall     (stall),
        .rdata_out (rdata_out),
        .fill_we   (fill_we),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // kind: 0 = load hit, 1 = load miss, 2 = store, 3 = load+store together.
    // delay: ack arrives in this wait cycle (1-based); > TO means never.
    task automatic run_txn(input int kind, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input int delay);
        int n_stall, n_rd, n_wr, n_fill, n_err, n_bad;
        bit is_wr, is_miss, ok;
        int eff;
        n_stall = 0; n_rd = 0; n_wr = 0; n_fill = 0; n_err = 0; n_bad = 0;
        is_wr   = (kind >= 2);
        is_miss = (kind == 1);
        ok      = (delay <= TO);
        eff     = ok ? delay : TO;
        if (is_miss && ok)
            exp_q.push_back({addr, data});

        @(negedge clk);
        cpu_re    = (kind != 2);
        cpu_we    = is_wr;
        cache_hit = (kind == 0);
        cpu_addr  = addr;
        cpu_wdata = data;
        for (int cyc = 0; cyc < WIN; cyc++) begin
            #1;
            if (stall) n_stall++;
            if (mem_rd) begin
                n_rd++;
                if (mem_addr !== addr) n_bad++;
            end
            if (mem_wr) begin
                n_wr++;
                if (mem_addr !== addr || mem_wdata !== data) n_bad++;
            end
            if (fill_we) begin
                n_fill++;
                if (exp_q.size() > 0)
                    check("fill_word", 32'({fill_addr, fill_data}), 32'(exp_q.pop_front()));
            end
            if (bus_err) n_err++;
            // SRAM responder; stray acks while nothing is pending must be ignored
            if ((mem_rd || mem_wr) && (n_rd + n_wr) == delay) begin
                mem_ack   = 1'b1;
                mem_rdata = is_wr ? DW'($urandom) : data;
            end else begin
                mem_ack   = !(mem_rd || mem_wr) && ($urandom_range(0, 3) == 0);
                mem_rdata = DW'($urandom);
            end
            @(negedge clk);
            cpu_re    = 1'b0;
            cpu_we    = 1'b0;
            cache_hit = 1'b0;
            cpu_addr  = AW'($urandom);
            cpu_wdata = DW'($urandom);
        end
        mem_ack = 1'b0;

        if (kind != 0 && !ok)
            exp_rdata = '1;
        else if (is_miss)
            exp_rdata = data;

        check("stall_cycles", n_stall, (kind == 0) ? 0 : 1 + eff);
        check("rd_cycles",    n_rd,    is_miss ? eff : 0);
        check("wr_cycles",    n_wr,    is_wr ? eff : 0);
        check("fill_count",   n_fill,  (is_miss && ok) ? 1 : 0);
        check("bus_err",      n_err,   (kind != 0 && !ok) ? 1 : 0);
        check("req_stable",   n_bad,   0);
        check("rdata_out",    32'(rdata_out), 32'(exp_rdata));
        check("fill_missing", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cpu_re = 1'b0; cpu_we = 1'b0; cache_hit = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        exp_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_stall",   stall, 0);
        check("rst_mem_rd",  mem_rd, 0);
        check("rst_mem_wr",  mem_wr, 0);
        check("rst_fill_we", fill_we, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_outs", 32'({rdata_out, mem_addr, fill_addr}), 0);
        @(negedge clk);
        rst = 1'b0;

        // directed cases
        run_txn(1, 8'h25, 16'hBEEF, 3);
        run_txn(0, 8'h25, 16'h0000, 1);
        run_txn(2, 8'h10, 16'h1234, 1);
        run_txn(1, 8'h3C, 16'h5A5A, 99);
        run_txn(1, 8'h11, 16'h0F0F, TO);
        run_txn(1, 8'h12, 16'h1111, 1);
        run_txn(2, 8'h22, 16'h7777, 99);
        run_txn(3, 8'h44, 16'hAAAA, 2);

        // reset while a read miss is outstanding
        @(negedge clk);
        cpu_re = 1'b1; cache_hit = 1'b0; cpu_addr = 8'h33;
        @(negedge clk);
        cpu_re = 1'b0;
        #1;
        check("pre_rst_mem_rd", mem_rd, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_mem_rd",  mem_rd, 0);
        check("mid_rst_stall",   stall, 0);
        check("mid_rst_fill_we", fill_we, 0);
        check("mid_rst_outs", 32'({rdata_out, mem_addr}), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_rdata = '0;
        run_txn(1, 8'h33, 16'hC0DE, 2);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            int k, r, d;
            k = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            d = (r == 0) ? TO + 1 + $urandom_range(0, 3) : (r == 1) ? TO : $urandom_range(1, 6);
            run_txn(k, AW'($urandom), DW'($urandom), d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
